tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter TIMEOUT, default 250000, number of clk cycles without a tone_in edge before silence is declared.
REQ-002 Parameter CONFIRM, default 3, number of consecutive same-class half-period measurements needed to accept a note.
REQ-003 clk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-005 tone_in  input  1  asynchronous square wave produced by the melody player's buzzer output.
REQ-006 note_code  output  4  accepted note: 0 = none, 1-4 = L1-L4, 5-8 = R1-R4.
REQ-007 note_valid  output  1  high while note_code is nonzero.
REQ-008 note_start  output  1  one-cycle pulse when note_code takes a new nonzero value.
REQ-009 seq_l_done  output  1  one-cycle pulse when L1,L2,L3,L4 are accepted in order.
REQ-010 seq_r_done  output  1  one-cycle pulse when R1,R2,R3,R4 are accepted in order.
REQ-011 half_period  output  18  most recent measured half-period in clk cycles.

Function
REQ-012 tone_in SHALL pass through a 2-flop synchronizer; a third register SHALL provide edge detection on both rising and falling transitions.
REQ-013 Half-period counter SHALL be 18 bits, saturate at 2^18-1, and yield measured = N exactly for a wave toggling every N clk cycles.
REQ-014 The first edge after reset or after a timeout SHALL only arm measurement and SHALL NOT produce a measurement.
REQ-015 Each measurement SHALL update half_period and be classified against nominals L1=50000, L2=25000, L3=16667, L4=12500, R1=191571, R2=151976, R3=127551, R4=90253.
REQ-016 A measurement SHALL match a nominal P when P - (P>>6) <= measured <= P + (P>>6); windows do not overlap; no match = class 0.
REQ-017 Match counter SHALL increment on a measurement whose class equals the previous measurement's nonzero class, reset to 1 on a new nonzero class, and reset to 0 on class 0.
REQ-018 When the match counter reaches CONFIRM and the class differs from note_code, note_code SHALL load the class and note_start SHALL pulse in the same cycle.
REQ-019 Class equal to current note_code SHALL NOT re-pulse note_start; a class-0 measurement SHALL leave note_code unchanged.
REQ-020 Latency: note_start SHALL rise exactly 3 clk after the first rising clk that samples the confirming tone_in transition.
REQ-021 When the counter reaches TIMEOUT without an edge: note_code=0, note_valid=0, match counter=0, measurement disarmed, sequence tracker to SQ_IDLE; no pulse is generated.
REQ-022 Sequence tracker states SHALL be SQ_IDLE, SQ_L (expected index 2-4), and SQ_R (expected index 6-8), advanced only on note_start.
REQ-023 SQ_IDLE: code 1 -> SQ_L expect 2; code 5 -> SQ_R expect 6; other codes stay in SQ_IDLE.
REQ-024 SQ_L/SQ_R: code == expected -> expected+1; expected 4 (or 8) matched -> seq_l_done (seq_r_done) pulses with that note_start and the tracker returns to SQ_IDLE.
REQ-025 SQ_L/SQ_R: an unexpected code SHALL restart at SQ_L/SQ_R if it is 1/5, else go to SQ_IDLE.
REQ-026 seq_l_done and seq_r_done SHALL never assert together, and neither SHALL be high for more than one cycle.

Reset
REQ-027 With reset low at a rising clk, all outputs, the synchronizer, counters and tracker SHALL be 0 / SQ_IDLE on the next cycle; tone_in is ignored while reset is low.
REQ-028 Reset asserted mid-note or mid-sequence SHALL abort with no pulse; after release, the first edge SHALL only re-arm measurement.

Verification
REQ-029 tone_in toggling every 50000 clk for 70 ms -> note_start once, note_code=1, half_period=50000, and note_start 3 clk after the 4th sampled edge.
REQ-030 L1..L4 with 7,000,000 clk each back-to-back, then silent -> 4 note_start pulses with codes 1,2,3,4, one seq_l_done with the code-4 note_start, note_code=0 after TIMEOUT clk of silence.
REQ-031 R1,R2,L3,R3,R4 -> no seq_r_done; tracker SQ_IDLE after L3; R4 does not complete a sequence.
REQ-032 Toggle every 49300 (in window) vs 49200 (out of window: 50000-781=49219) -> code 1 accepted vs note_code stays 0.
REQ-033 Toggle every 12500 with one 20000 half-period inserted before the 3rd match -> confirmation delayed to 3 further consecutive matches.
REQ-034 reset low for 1 clk during R3 of an R sequence, then R4 -> note_code=8 with no seq_r_done.

Source files
------------

// File: rtl/tone_decoder.sv
// Half-period tone decoder: measures a buzzer square wave, classifies it against the
// L1-L4 / R1-R4 note table, confirms notes and tracks the L and R melody sequences.
module tone_decoder #(
    parameter int unsigned TIMEOUT     = 250000,
    parameter int unsigned CONFIRM     = 3,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tone_in,
    output logic [3:0]  note_code,
    output logic        note_valid,
    output logic        note_start,
    output logic        seq_l_done,
    output logic        seq_r_done,
    output logic [17:0] half_period
);

    localparam int unsigned CW = 18;
    localparam int unsigned MW = 8;
    localparam int unsigned NW = 4;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [MW-1:0] MATCH_MAX = '1;
    localparam logic [MW-1:0] CONFIRM_C = MW'(CONFIRM);
    // Nominal half-periods in clk cycles (L1..L4, R1..R4), optionally scaled down by 2^SCALE_SHIFT
    localparam int unsigned NOM [8] = '{
        50000 >> SCALE_SHIFT,  25000 >> SCALE_SHIFT,  16667 >> SCALE_SHIFT, 12500 >> SCALE_SHIFT,
        191571 >> SCALE_SHIFT, 151976 >> SCALE_SHIFT, 127551 >> SCALE_SHIFT, 90253 >> SCALE_SHIFT
    };

    typedef enum logic [1:0] {SQ_IDLE, SQ_L, SQ_R} sq_e;

    function automatic logic [NW-1:0] classify(input logic [CW-1:0] m);
        logic [NW-1:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            if (m >= CW'(NOM[i] - (NOM[i] >> 6)) && m <= CW'(NOM[i] + (NOM[i] >> 6)))
                c = NW'(i + 1);
        end
        return c;
    endfunction

    logic          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CW-1:0] cnt_q, cnt_d, half_q, half_d;
    logic          armed_q, armed_d, meas_q, meas_d;
    logic [NW-1:0] cls_q, cls_d, last_q, last_d, code_q, code_d, exp_q, exp_d;
    logic [MW-1:0] match_q, match_d;
    logic          valid_q, valid_d, start_q, start_d, ldone_q, ldone_d, rdone_q, rdone_d;
    sq_e           sq_q, sq_d;
    logic          edge_c;

    assign edge_c = sync2_q ^ sync3_q;

    always_comb begin
        sync1_d = tone_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        armed_d = armed_q;
        meas_d  = 1'b0;
        cls_d   = cls_q;
        last_d  = last_q;
        match_d = match_q;
        code_d  = code_q;
        start_d = 1'b0;
        ldone_d = 1'b0;
        rdone_d = 1'b0;
        sq_d    = sq_q;
        exp_d   = exp_q;

        // Stage 1: measure the interval ending at this edge; the first edge only arms
        if (edge_c) begin
            cnt_d = CW'(1);
            if (armed_q) begin
                meas_d = 1'b1;
                half_d = cnt_q;
                cls_d  = classify(cnt_q);
            end else begin
                armed_d = 1'b1;
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Stage 2: confirmation counter, note acceptance and sequence tracking
        if (meas_q) begin
            last_d = cls_q;
            if (cls_q == '0)
                match_d = '0;
            else if (cls_q == last_q)
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            else
                match_d = MW'(1);

            if (cls_q != '0 && match_d >= CONFIRM_C && cls_q != code_q) begin
                code_d  = cls_q;
                start_d = 1'b1;
                if (sq_q != SQ_IDLE && cls_q == exp_q) begin
                    if (exp_q == NW'(4) || exp_q == NW'(8)) begin
                        ldone_d = (sq_q == SQ_L);
                        rdone_d = (sq_q == SQ_R);
                        sq_d    = SQ_IDLE;
                        exp_d   = '0;
                    end else begin
                        exp_d = exp_q + 1'b1;
                    end
                end else if (cls_q == NW'(1)) begin
                    sq_d  = SQ_L;
                    exp_d = NW'(2);
                end else if (cls_q == NW'(5)) begin
                    sq_d  = SQ_R;
                    exp_d = NW'(6);
                end else begin
                    sq_d  = SQ_IDLE;
                    exp_d = '0;
                end
            end
        end

        // Silence: drop the note and all tracking state without any pulse
        if (!edge_c && cnt_q == TIMEOUT_C) begin
            code_d  = '0;
            match_d = '0;
            last_d  = '0;
            armed_d = 1'b0;
            start_d = 1'b0;
            ldone_d = 1'b0;
            rdone_d = 1'b0;
            sq_d    = SQ_IDLE;
            exp_d   = '0;
        end

        valid_d = (code_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
            half_q  <= '0;
            armed_q <= 1'b0;
            meas_q  <= 1'b0;
            cls_q   <= '0;
            last_q  <= '0;
            match_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            ldone_q <= 1'b0;
            rdone_q <= 1'b0;
            sq_q    <= SQ_IDLE;
            exp_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            armed_q <= armed_d;
            meas_q  <= meas_d;
            cls_q   <= cls_d;
            last_q  <= last_d;
            match_q <= match_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            start_q <= start_d;
            ldone_q <= ldone_d;
            rdone_q <= rdone_d;
            sq_q    <= sq_d;
            exp_q   <= exp_d;
        end
    end

    assign note_code   = code_q;
    assign note_valid  = valid_q;
    assign note_start  = start_q;
    assign seq_l_done  = ldone_q;
    assign seq_r_done  = rdone_q;
    assign half_period = half_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder with nominals scaled by 2^7 (L1=390 L2=195 L3=130 L4=97,
// R1=1496 R2=1187 R3=996 R4=705) and TIMEOUT=2000.
module tb_tone_decoder;

    logic        clk;
    logic        reset;
    logic        tone_in;
    logic [3:0]  note_code;
    logic        note_valid;
    logic        note_start;
    logic        seq_l_done;
    logic        seq_r_done;
    logic [17:0] half_period;

    int checks = 0;
    int fails  = 0;

    tone_decoder #(.TIMEOUT(2000), .CONFIRM(3), .SCALE_SHIFT(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .tone_in    (tone_in),
        .note_code  (note_code),
        .note_valid (note_valid),
        .note_start (note_start),
        .seq_l_done (seq_l_done),
        .seq_r_done (seq_r_done),
        .half_period(half_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: counts pulses and records the code seen with each note_start
    int         n_start = 0;
    int         n_ldone = 0;
    int         n_rdone = 0;
    int         n_excl  = 0;
    logic [3:0] start_code [64];
    logic [3:0] ldone_code = '0;
    logic       ldone_with_start = 1'b0;
    logic       prev_l = 1'b0;
    logic       prev_r = 1'b0;

    always @(negedge clk) begin
        prev_l <= seq_l_done;
        prev_r <= seq_r_done;
        if ((seq_l_done && seq_r_done) || (seq_l_done && prev_l) || (seq_r_done && prev_r))
            n_excl <= n_excl + 1;
        if (note_start) begin
            if (n_start < 64) start_code[n_start] <= note_code;
            n_start <= n_start + 1;
        end
        if (seq_l_done) begin
            n_ldone          <= n_ldone + 1;
            ldone_code       <= note_code;
            ldone_with_start <= note_start;
        end
        if (seq_r_done) n_rdone <= n_rdone + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle(input int half, input int n);
        repeat (n) begin
            tone_in = ~tone_in;
            tick(half);
        end
    endtask

    task automatic do_reset;
        reset   = 1'b0;
        tone_in = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        tone_in = 1'b1;
        tick(3);
        checks++;
        if ({note_code, note_valid, note_start, seq_l_done, seq_r_done, half_period} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {note_code, note_valid, note_start, seq_l_done, seq_r_done, half_period});
        end
        tone_in = 1'b0;
        reset   = 1'b1;
        tick(1);
    endtask

    task automatic test_single_note;
        int b;
        do_reset();
        b = n_start;
        toggle(390, 3);
        tone_in = ~tone_in;
        tick(3);
        checks++;
        if (note_start !== 1'b0) begin
            fails++; $display("FAIL single_start_early: got %0b expected 0", note_start);
        end
        tick(1);
        checks++;
        if (note_start !== 1'b1) begin
            fails++; $display("FAIL single_start_latency: got %0b expected 1", note_start);
        end
        checks++;
        if (note_code !== 4'd1) begin
            fails++; $display("FAIL single_code: got %0d expected 1", note_code);
        end
        checks++;
        if (half_period !== 18'd390) begin
            fails++; $display("FAIL single_half_period: got %0d expected 390", half_period);
        end
        tick(1);
        checks++;
        if (note_start !== 1'b0) begin
            fails++; $display("FAIL single_start_width: got %0b expected 0", note_start);
        end
        tick(385);
        toggle(390, 4);
        tick(5);
        checks++;
        if (n_start - b !== 1) begin
            fails++; $display("FAIL single_start_count: got %0d expected 1", n_start - b);
        end
        checks++;
        if (note_valid !== 1'b1) begin
            fails++; $display("FAIL single_valid: got %0b expected 1", note_valid);
        end
    endtask

    task automatic test_l_sequence;
        int         b;
        int         bl;
        logic [3:0] exp_codes [4];
        exp_codes = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        b  = n_start;
        bl = n_ldone;
        toggle(390, 5);
        toggle(195, 4);
        toggle(130, 4);
        toggle(97, 4);
        checks++;
        if (n_start - b !== 4) begin
            fails++; $display("FAIL lseq_start_count: got %0d expected 4", n_start - b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (start_code[b + i] !== exp_codes[i]) begin
                fails++;
                $display("FAIL lseq_code%0d: got %0d expected %0d", i, start_code[b + i], exp_codes[i]);
            end
        end
        checks++;
        if (n_ldone - bl !== 1) begin
            fails++; $display("FAIL lseq_done_count: got %0d expected 1", n_ldone - bl);
        end
        checks++;
        if ({ldone_with_start, ldone_code} !== 5'b1_0100) begin
            fails++;
            $display("FAIL lseq_done_with_l4: got start=%0b code=%0d expected start=1 code=4",
                     ldone_with_start, ldone_code);
        end
        checks++;
        if (note_code !== 4'd4) begin
            fails++; $display("FAIL lseq_code_before_silence: got %0d expected 4", note_code);
        end
        tick(2000);
        checks++;
        if ({note_code, note_valid} !== 5'd0) begin
            fails++;
            $display("FAIL lseq_timeout: got code=%0d valid=%0b expected 0/0", note_code, note_valid);
        end
        checks++;
        if (n_start - b !== 4 || n_ldone - bl !== 1) begin
            fails++;
            $display("FAIL lseq_timeout_pulse: got starts=%0d ldone=%0d expected 4/1",
                     n_start - b, n_ldone - bl);
        end
    endtask

    task automatic test_r_broken;
        int         b;
        int         br;
        logic [3:0] exp_codes [5];
        exp_codes = '{4'd5, 4'd6, 4'd3, 4'd7, 4'd8};
        do_reset();
        b  = n_start;
        br = n_rdone;
        toggle(1496, 5);
        toggle(1187, 4);
        toggle(130, 4);
        toggle(996, 4);
        toggle(705, 4);
        checks++;
        if (n_start - b !== 5) begin
            fails++; $display("FAIL rbrk_start_count: got %0d expected 5", n_start - b);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (start_code[b + i] !== exp_codes[i]) begin
                fails++;
                $display("FAIL rbrk_code%0d: got %0d expected %0d", i, start_code[b + i], exp_codes[i]);
            end
        end
        checks++;
        if (n_rdone - br !== 0) begin
            fails++; $display("FAIL rbrk_no_done: got %0d expected 0", n_rdone - br);
        end
        checks++;
        if (note_code !== 4'd8) begin
            fails++; $display("FAIL rbrk_final_code: got %0d expected 8", note_code);
        end
    endtask

    task automatic test_window;
        int b;
        do_reset();
        b = n_start;
        toggle(385, 5);
        checks++;
        if (note_code !== 4'd1 || n_start - b !== 1) begin
            fails++;
            $display("FAIL window_inside: got code=%0d starts=%0d expected 1/1", note_code, n_start - b);
        end
        do_reset();
        b = n_start;
        toggle(383, 5);
        checks++;
        if (note_code !== 4'd0 || note_valid !== 1'b0 || n_start - b !== 0) begin
            fails++;
            $display("FAIL window_outside: got code=%0d valid=%0b starts=%0d expected 0/0/0",
                     note_code, note_valid, n_start - b);
        end
        checks++;
        if (half_period !== 18'd383) begin
            fails++; $display("FAIL window_half_period: got %0d expected 383", half_period);
        end
    endtask

    task automatic test_glitch;
        int b;
        do_reset();
        b = n_start;
        toggle(97, 2);
        toggle(156, 1);
        toggle(97, 3);
        checks++;
        if (n_start - b !== 0 || note_code !== 4'd0) begin
            fails++;
            $display("FAIL glitch_early_accept: got starts=%0d code=%0d expected 0/0", n_start - b, note_code);
        end
        tone_in = ~tone_in;
        tick(3);
        checks++;
        if (note_start !== 1'b0) begin
            fails++; $display("FAIL glitch_start_early: got %0b expected 0", note_start);
        end
        tick(1);
        checks++;
        if (note_start !== 1'b1 || note_code !== 4'd4) begin
            fails++;
            $display("FAIL glitch_confirm: got start=%0b code=%0d expected 1/4", note_start, note_code);
        end
        tick(100);
    endtask

    task automatic test_reset_mid_seq;
        int b;
        int br;
        do_reset();
        br = n_rdone;
        toggle(1496, 5);
        toggle(1187, 4);
        toggle(996, 2);
        reset = 1'b0;
        tick(1);
        checks++;
        if ({note_code, note_valid, note_start, seq_l_done, seq_r_done, half_period} !== 26'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h expected 0",
                     {note_code, note_valid, note_start, seq_l_done, seq_r_done, half_period});
        end
        reset = 1'b1;
        b = n_start;
        toggle(705, 5);
        checks++;
        if (note_code !== 4'd8 || n_start - b !== 1) begin
            fails++;
            $display("FAIL midreset_r4: got code=%0d starts=%0d expected 8/1", note_code, n_start - b);
        end
        checks++;
        if (n_rdone - br !== 0) begin
            fails++; $display("FAIL midreset_no_done: got %0d expected 0", n_rdone - br);
        end
    endtask

    task automatic test_done_exclusive;
        checks++;
        if (n_excl !== 0) begin
            fails++; $display("FAIL done_exclusive: got %0d violations expected 0", n_excl);
        end
    endtask

    initial begin
        reset   = 1'b0;
        tone_in = 1'b0;
        test_reset();
        test_single_note();
        test_l_sequence();
        test_r_broken();
        test_window();
        test_glitch();
        test_reset_mid_seq();
        test_done_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
